// File: rtl/clic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clic_pkg
// Description : Shared constants, FSM state type and level-decode helper for
//               the CLIC priority arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package clic_pkg;

  localparam int CLICINTCTLBITS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    CLAIM   = 2'd3
  } arb_state_e;

  // The upper nlbits of ctl carry the level; the remaining low bits read as 1.
  // nlbits above 8 behaves like 8, and nlbits == 0 yields level 0xFF.
  function automatic logic [CLICINTCTLBITS-1:0] clic_level(
    input logic [CLICINTCTLBITS-1:0] ctl,
    input logic [3:0]                nlbits
  );
    logic [3:0] n;
    n = (nlbits > 4'd8) ? 4'd8 : nlbits;
    return ctl | (8'hFF >> n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clic_scan_cmp.sv
`default_nettype none
// ============================================================================
// Module      : clic_scan_cmp
// Description : Combinational compare over one scan chunk. Picks the eligible
//               candidate with the largest ctl; on equal ctl the higher
//               offset wins.
// Revision    : 1.0 - initial release
// ============================================================================
module clic_scan_cmp
  import clic_pkg::*;
#(
  parameter int SCAN_WIDTH = 8,
  parameter int OFFW       = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1
) (
  input  logic [SCAN_WIDTH-1:0]                cand_valid,
  input  logic [SCAN_WIDTH*CLICINTCTLBITS-1:0] cand_ctl,
  output logic                                 best_valid,
  output logic [OFFW-1:0]                      best_off,
  output logic [CLICINTCTLBITS-1:0]            best_ctl
);

  // Ascending walk with >= lets the higher offset win a ctl tie.
  always_comb begin
    best_valid = 1'b0;
    best_off   = '0;
    best_ctl   = '0;
    for (int i = 0; i < SCAN_WIDTH; i++) begin
      if (cand_valid[i] &&
          (!best_valid || (cand_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS] >= best_ctl))) begin
        best_valid = 1'b1;
        best_off   = OFFW'(i);
        best_ctl   = cand_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clic_arbiter
// Description : CLIC priority arbiter. Sweeps the interrupt state one chunk
//               per cycle, keeps a running best, presents the winner over a
//               valid/ready claim handshake and withdraws it if it loses
//               eligibility. Optional feature macro: CLIC_ARB_SHV_EN adds
//               int_shv / irq_shv (selective hardware vectoring bit).
// Revision    : 1.0 - initial release
// ============================================================================
module clic_arbiter
  import clic_pkg::*;
#(
  parameter int NUM_INT    = 64,
  parameter int SCAN_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_INT-1:0]                  int_ip,
  input  logic [NUM_INT-1:0]                  int_ie,
  input  logic [NUM_INT*CLICINTCTLBITS-1:0]   int_ctl,
  input  logic [3:0]                          nlbits,
  input  logic [7:0]                          cur_level,
  input  logic [7:0]                          threshold,
`ifdef CLIC_ARB_SHV_EN
  input  logic [NUM_INT-1:0]                  int_shv,
  output logic                                irq_shv,
`endif
  output logic                                irq_valid,
  output logic [$clog2(NUM_INT)-1:0]          irq_id,
  output logic [7:0]                          irq_level,
  input  logic                                irq_ready,
  output logic                                claim_pulse,
  output logic [$clog2(NUM_INT)-1:0]          claim_id
);

  localparam int NUM_CHUNK = NUM_INT / SCAN_WIDTH;
  localparam int IDW       = $clog2(NUM_INT);
  localparam int CNTW      = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
  localparam int OFFW      = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;
  localparam int CB        = CLICINTCTLBITS;

  arb_state_e             state, state_nxt;
  logic [CNTW-1:0]        cnt;
  logic                   best_valid;
  logic [IDW-1:0]         best_id;
  logic [CB-1:0]          best_ctl;

  logic [IDW-1:0]         chunk_base;
  logic [SCAN_WIDTH-1:0]  chunk_ip, chunk_ie, chunk_elig;
  logic [SCAN_WIDTH*CB-1:0] chunk_ctl;
  logic                   cmp_valid;
  logic [OFFW-1:0]        cmp_off;
  logic [CB-1:0]          cmp_ctl;
  logic                   merge_valid;
  logic [IDW-1:0]         merge_id;
  logic [CB-1:0]          merge_ctl;
  logic                   last_chunk;
  logic [CB-1:0]          held_ctl, held_lvl;
  logic                   held_elig;

  assign last_chunk = (cnt == CNTW'(NUM_CHUNK - 1));
  assign chunk_base = IDW'(cnt * SCAN_WIDTH);
  assign chunk_ip   = int_ip[chunk_base +: SCAN_WIDTH];
  assign chunk_ie   = int_ie[chunk_base +: SCAN_WIDTH];
  assign chunk_ctl  = int_ctl[chunk_base*CB +: SCAN_WIDTH*CB];

  generate
    for (genvar j = 0; j < SCAN_WIDTH; j++) begin : g_elig
      logic [CB-1:0] lvl;
      assign lvl = clic_level(chunk_ctl[j*CB +: CB], nlbits);
      assign chunk_elig[j] = chunk_ip[j] & chunk_ie[j] &
                             (lvl > cur_level) & (lvl > threshold);
    end
  endgenerate

  clic_scan_cmp #(
    .SCAN_WIDTH (SCAN_WIDTH),
    .OFFW       (OFFW)
  ) u_scan_cmp (
    .cand_valid (chunk_elig),
    .cand_ctl   (chunk_ctl),
    .best_valid (cmp_valid),
    .best_off   (cmp_off),
    .best_ctl   (cmp_ctl)
  );

  // Presented interrupt is re-qualified against live inputs every cycle.
  assign held_ctl  = int_ctl[irq_id*CB +: CB];
  assign held_lvl  = clic_level(held_ctl, nlbits);
  assign held_elig = int_ip[irq_id] & int_ie[irq_id] &
                     (held_lvl > cur_level) & (held_lvl > threshold);

  // Fold this chunk's winner into the running best; chunk ids are always
  // higher than earlier ones, so the chunk wins a ctl tie.
  always_comb begin
    merge_valid = best_valid;
    merge_id    = best_id;
    merge_ctl   = best_ctl;
    if (cmp_valid && (!best_valid || (cmp_ctl >= best_ctl))) begin
      merge_valid = 1'b1;
      merge_id    = chunk_base + IDW'(cmp_off);
      merge_ctl   = cmp_ctl;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; withdrawal outranks irq_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SCAN;
      SCAN:    if (last_chunk && merge_valid) state_nxt = PRESENT;
      PRESENT: begin
        if (!held_elig)     state_nxt = SCAN;
        else if (irq_ready) state_nxt = CLAIM;
      end
      CLAIM:   state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_valid   = (state == PRESENT);
  assign claim_pulse = (state == CLAIM);

  // Chunk counter, running best and the held winner / claimed id.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      best_valid <= 1'b0;
      best_id    <= '0;
      best_ctl   <= '0;
      irq_id     <= '0;
      irq_level  <= '0;
      claim_id   <= '0;
    end else begin
      if (state == SCAN) begin
        if (last_chunk) begin
          cnt        <= '0;
          best_valid <= 1'b0;
          best_id    <= '0;
          best_ctl   <= '0;
          if (merge_valid) begin
            irq_id    <= merge_id;
            irq_level <= clic_level(merge_ctl, nlbits);
          end
        end else begin
          cnt        <= cnt + 1'b1;
          best_valid <= merge_valid;
          best_id    <= merge_id;
          best_ctl   <= merge_ctl;
        end
      end else begin
        cnt        <= '0;
        best_valid <= 1'b0;
        best_id    <= '0;
        best_ctl   <= '0;
      end
      if ((state == PRESENT) && held_elig && irq_ready)
        claim_id <= irq_id;
    end
  end

`ifdef CLIC_ARB_SHV_EN
  // Vectoring bit of the winner, captured alongside irq_id.
  always_ff @(posedge clk) begin
    if (rst)
      irq_shv <= 1'b0;
    else if ((state == SCAN) && last_chunk && merge_valid)
      irq_shv <= int_shv[merge_id];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clic_arbiter
// Description : Directed self-checking bench for clic_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clic_arbiter;

  localparam int NUM_INT = 64;
  localparam int SW      = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_INT-1:0]   int_ip, int_ie;
  logic [NUM_INT*8-1:0] int_ctl;
  logic [3:0]           nlbits;
  logic [7:0]           cur_level, threshold;
  logic                 irq_valid, irq_ready, claim_pulse;
  logic [5:0]           irq_id, claim_id;
  logic [7:0]           irq_level;
`ifdef CLIC_ARB_SHV_EN
  logic [NUM_INT-1:0]   int_shv;
  logic                 irq_shv;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clic_arbiter #(.NUM_INT(NUM_INT), .SCAN_WIDTH(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .int_ip      (int_ip),
    .int_ie      (int_ie),
    .int_ctl     (int_ctl),
    .nlbits      (nlbits),
    .cur_level   (cur_level),
    .threshold   (threshold),
`ifdef CLIC_ARB_SHV_EN
    .int_shv     (int_shv),
    .irq_shv     (irq_shv),
`endif
    .irq_valid   (irq_valid),
    .irq_id      (irq_id),
    .irq_level   (irq_level),
    .irq_ready   (irq_ready),
    .claim_pulse (claim_pulse),
    .claim_id    (claim_id)
  );

  task automatic clear_inputs();
    int_ip = '0; int_ie = '0; int_ctl = '0;
    nlbits = 4'd8; cur_level = 8'h00; threshold = 8'h00; irq_ready = 1'b0;
`ifdef CLIC_ARB_SHV_EN
    int_shv = '0;
`endif
  endtask

  task automatic set_int(input int id, input logic [7:0] ctl);
    int_ip[id] = 1'b1;
    int_ie[id] = 1'b1;
    int_ctl[id*8 +: 8] = ctl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of negedges until irq_valid, or -1 on timeout.
  task automatic wait_valid(input int max_cycles, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      if (!done) begin
        @(negedge clk);
        if (irq_valid === 1'b1) begin
          cyc  = i;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic watch_quiet(input int n, output int seen_valid, output int seen_claim);
    seen_valid = 0;
    seen_claim = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (irq_valid !== 1'b0)   seen_valid++;
      if (claim_pulse !== 1'b0) seen_claim++;
    end
  endtask

  task automatic test_reset();
    int sv, sc;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_id !== 6'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    checks++; if (irq_level !== 8'h00) begin errors++; $display("FAIL reset_level got=%h exp=00", irq_level); end
    checks++; if (claim_pulse !== 1'b0) begin errors++; $display("FAIL reset_claim_pulse got=%b exp=0", claim_pulse); end
    checks++; if (claim_id !== 6'd0) begin errors++; $display("FAIL reset_claim_id got=%0d exp=0", claim_id); end
    rst = 1'b0;
    watch_quiet(20, sv, sc);
    checks++; if (sv !== 0) begin errors++; $display("FAIL reset_idle_valid got=%0d exp=0", sv); end
  endtask

  task automatic test_single();
    int cyc;
    clear_inputs();
    nlbits = 4'd5;
    set_int(5, 8'hA0);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL single_latency got=%0d exp=9", cyc); end
    checks++; if (irq_id !== 6'd5) begin errors++; $display("FAIL single_id got=%0d exp=5", irq_id); end
    checks++; if (irq_level !== 8'hA7) begin errors++; $display("FAIL single_level got=%h exp=a7", irq_level); end
  endtask

  task automatic test_tiebreak();
    int cyc;
    clear_inputs();
    set_int(3, 8'h80);
    set_int(40, 8'h80);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (irq_id !== 6'd40) begin errors++; $display("FAIL tie_id got=%0d exp=40", irq_id); end
    checks++; if (irq_level !== 8'h80) begin errors++; $display("FAIL tie_level got=%h exp=80", irq_level); end
    int_ctl[3*8 +: 8] = 8'h81;
    repeat (12) @(negedge clk);
    checks++; if ({irq_valid, irq_id} !== {1'b1, 6'd40}) begin errors++; $display("FAIL tie_nopreempt got=%b/%0d exp=1/40", irq_valid, irq_id); end
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    checks++; if (claim_pulse !== 1'b1) begin errors++; $display("FAIL tie_claim_pulse got=%b exp=1", claim_pulse); end
    checks++; if (claim_id !== 6'd40) begin errors++; $display("FAIL tie_claim_id got=%0d exp=40", claim_id); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL tie_claim_valid got=%b exp=0", irq_valid); end
    wait_valid(17, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL tie_rescan_latency got=%0d exp=9", cyc); end
    checks++; if (irq_id !== 6'd3) begin errors++; $display("FAIL tie_rescan_id got=%0d exp=3", irq_id); end
    checks++; if (irq_level !== 8'h81) begin errors++; $display("FAIL tie_rescan_level got=%h exp=81", irq_level); end
  endtask

  task automatic test_threshold();
    int cyc, sv, sc;
    clear_inputs();
    nlbits = 4'd5;
    set_int(12, 8'h40);
    threshold = 8'h47;
    do_reset();
    watch_quiet(25, sv, sc);
    checks++; if (sv !== 0) begin errors++; $display("FAIL thr_equal_presented got=%0d exp=0", sv); end
    threshold = 8'h46;
    wait_valid(17, cyc);
    checks++; if (cyc < 1) begin errors++; $display("FAIL thr_below_timeout got=%0d exp=1..17", cyc); end
    checks++; if (irq_id !== 6'd12) begin errors++; $display("FAIL thr_id got=%0d exp=12", irq_id); end
    checks++; if (irq_level !== 8'h47) begin errors++; $display("FAIL thr_level got=%h exp=47", irq_level); end
    cur_level = 8'h47;
    @(negedge clk);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL thr_curlevel_withdraw got=%b exp=0", irq_valid); end
    watch_quiet(25, sv, sc);
    checks++; if (sv !== 0) begin errors++; $display("FAIL thr_curlevel_presented got=%0d exp=0", sv); end
  endtask

  task automatic test_claim();
    int cyc, sv, sc;
    clear_inputs();
    set_int(9, 8'h90);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (irq_id !== 6'd9) begin errors++; $display("FAIL claim_present_id got=%0d exp=9", irq_id); end
    irq_ready = 1'b1;
    @(negedge clk);
    checks++; if (claim_pulse !== 1'b1) begin errors++; $display("FAIL claim_pulse got=%b exp=1", claim_pulse); end
    checks++; if (claim_id !== 6'd9) begin errors++; $display("FAIL claim_id got=%0d exp=9", claim_id); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL claim_valid got=%b exp=0", irq_valid); end
    int_ip[9] = 1'b0;
    watch_quiet(25, sv, sc);
    irq_ready = 1'b0;
    checks++; if (sv !== 0) begin errors++; $display("FAIL claim_represent got=%0d exp=0", sv); end
    checks++; if (sc !== 0) begin errors++; $display("FAIL claim_ready_ignored got=%0d exp=0", sc); end
  endtask

  task automatic test_withdraw();
    int cyc;
    clear_inputs();
    set_int(20, 8'hC0);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (irq_id !== 6'd20) begin errors++; $display("FAIL wd_present_id got=%0d exp=20", irq_id); end
    int_ie[20] = 1'b0;
    irq_ready  = 1'b1;
    @(negedge clk);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL wd_valid got=%b exp=0", irq_valid); end
    checks++; if (claim_pulse !== 1'b0) begin errors++; $display("FAIL wd_claim_pulse got=%b exp=0", claim_pulse); end
    @(negedge clk);
    checks++; if (claim_pulse !== 1'b0) begin errors++; $display("FAIL wd_claim_late got=%b exp=0", claim_pulse); end
    irq_ready = 1'b0;
  endtask

  task automatic test_level_decode();
    int cyc;
    clear_inputs();
    nlbits = 4'd12;
    set_int(60, 8'h35);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (irq_id !== 6'd60) begin errors++; $display("FAIL lvl_id got=%0d exp=60", irq_id); end
    checks++; if (irq_level !== 8'h35) begin errors++; $display("FAIL lvl_nlbits12 got=%h exp=35", irq_level); end
    nlbits    = 4'd0;
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    wait_valid(17, cyc);
    checks++; if (irq_level !== 8'hFF) begin errors++; $display("FAIL lvl_nlbits0 got=%h exp=ff", irq_level); end
  endtask

  task automatic test_rst_mid();
    int cyc;
    clear_inputs();
    set_int(33, 8'h70);
    do_reset();
    wait_valid(17, cyc);
    checks++; if (irq_id !== 6'd33) begin errors++; $display("FAIL rst_present_id got=%0d exp=33", irq_id); end
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_id !== 6'd0) begin errors++; $display("FAIL rst_mid_id got=%0d exp=0", irq_id); end
    checks++; if (irq_level !== 8'h00) begin errors++; $display("FAIL rst_mid_level got=%h exp=00", irq_level); end
    checks++; if (claim_id !== 6'd0) begin errors++; $display("FAIL rst_mid_claim_id got=%0d exp=0", claim_id); end
    rst = 1'b0;
    wait_valid(17, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL rst_mid_relatency got=%0d exp=9", cyc); end
    checks++; if (irq_id !== 6'd33) begin errors++; $display("FAIL rst_mid_reid got=%0d exp=33", irq_id); end
    rst       = 1'b1;
    irq_ready = 1'b1;
    @(negedge clk);
    checks++; if (claim_pulse !== 1'b0) begin errors++; $display("FAIL rst_hs_claim_pulse got=%b exp=0", claim_pulse); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rst_hs_valid got=%b exp=0", irq_valid); end
    rst       = 1'b0;
    irq_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_tiebreak();
    test_threshold();
    test_claim();
    test_withdraw();
    test_level_decode();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/clic_arbiter.md
# clic_arbiter

Priority arbiter and handshake sequencer for the CLIC interrupt controller. Each cycle it scans a chunk of the per-interrupt pending, enable and control state (`clicintip`, `clicintie`, `clicintctl`). It selects the highest-ranked eligible interrupt, where eligible means its level exceeds both the hart's current interrupt level and the level threshold. It presents the winner to the hart over a valid/ready claim handshake. It sits between the CLIC register file and the hart's trap-entry logic.

## Interface
- `NUM_INT`, 64: number of interrupt sources; must be a multiple of `SCAN_WIDTH`.
- `CLICINTCTLBITS`, 8: width of each control field.
- `SCAN_WIDTH`, 8: interrupts compared per scan cycle.
- `clk`  in  1  clock; the block uses a single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `int_ip`  in  NUM_INT  pending bits.
- `int_ie`  in  NUM_INT  enable bits.
- `int_ctl`  in  NUM_INT*CLICINTCTLBITS  packed control fields; interrupt i occupies bits [i*8 +: 8].
- `nlbits`  in  4  level-bit count from `cliccfg[4:1]`; values above 8 are treated as 8.
- `cur_level`  in  8  hart's current interrupt level (mintstatus.mil).
- `threshold`  in  8  mintthresh.
- `irq_valid`  out  1  a winner is presented.
- `irq_id`  out  clog2(NUM_INT)  winner id.
- `irq_level`  out  8  winner's decoded level.
- `irq_ready`  in  1  hart takes the interrupt.
- `claim_pulse`  out  1  one-cycle pulse when the handshake completes.
- `claim_id`  out  clog2(NUM_INT)  id being claimed; valid while `claim_pulse` is high.

## Operation
- Level decode: the upper `nlbits` bits of ctl form the level MSBs; the remaining low bits are forced to 1. With `nlbits`=0, the level is 0xFF.
- Eligibility: ip & ie & (level > cur_level) & (level > threshold).
- Rank: the larger full 8-bit ctl value wins. On equal ctl, the higher id wins.
- FSM:
  - IDLE: entered at reset; goes to SCAN on the next cycle.
  - SCAN: chunk counter runs from 0 to S-1, where S = NUM_INT/SCAN_WIDTH.
    - Each cycle, the chunk's best candidate is merged into a running best register.
    - At the end of the sweep: if a candidate exists, go to PRESENT; otherwise restart SCAN with the running best cleared.
  - PRESENT: `irq_valid`=1.
    - `irq_id` and `irq_level` are held stable.
    - The held candidate is re-checked for eligibility every cycle. If it becomes ineligible, go to SCAN (withdraw).
    - On `irq_valid & irq_ready` with the candidate still eligible, go to CLAIM.
  - CLAIM: one cycle.
    - `claim_pulse`=1 and `claim_id` = held id.
    - Then go to SCAN.
- A higher-ranked interrupt arriving during PRESENT does not preempt the presented one; it is picked up by the next sweep.
- Withdrawal takes priority over `irq_ready` in the same cycle. The claim is not issued.

## Timing
- Reset values: `irq_valid`=0, `irq_id`=0, `irq_level`=0, `claim_pulse`=0, `claim_id`=0, FSM=IDLE, chunk counter=0.
- Sweep latency: S cycles. `irq_valid` rises the cycle after the last chunk.
- Worst-case latency from an interrupt becoming eligible to `irq_valid`: 2S+1 cycles.
- Inputs are sampled in the chunk's cycle. A change after its chunk has been scanned is seen on the next sweep.
- Handshake:
  - `irq_ready` is ignored while `irq_valid`=0.
  - Handshake at cycle t gives `claim_pulse` at t+1 and `irq_valid`=0 at t+1.
- Withdrawal: the candidate is ineligible at cycle t, and `irq_valid`=0 at t+1.
- `rst` asserted mid-sweep or mid-handshake returns the block to the reset state at the next edge. No claim is issued.

## Configuration
- `CLIC_ARB_SHV_EN` defined:
  - Adds input `int_shv` (NUM_INT wide) and output `irq_shv` (1 bit).
  - `irq_shv` is the winner's selective-hardware-vectoring bit, registered and held alongside `irq_id`. Its reset value is 0.
- `CLIC_ARB_SHV_EN` undefined: the ports are absent, and all interrupts are non-vectored (nvbits=0).

## Structure
- Package `clic_pkg` holds:
  - the `CLICINTCTLBITS` constant;
  - the FSM state enum (IDLE, SCAN, PRESENT, CLAIM);
  - function `clic_level(ctl, nlbits)`.
- Sub-module `clic_scan_cmp`: a combinational SCAN_WIDTH-input compare tree. It outputs chunk-best valid, id offset and ctl.

## Test plan
Defaults for all scenarios: NUM_INT=64, SCAN_WIDTH=8, so S=8.
- Reset: hold `rst` for 3 cycles -> all outputs 0 and `irq_valid` stays 0 with no pending interrupts.
- Single interrupt: id 5, ctl=0xA0, nlbits=5, cur_level=0, threshold=0 -> `irq_valid` within 17 cycles, `irq_id`=5, `irq_level`=0xA7.
- Tie-break: ids 3 and 40 both with ctl=0x80 -> `irq_id`=40. Then change id 3 to ctl=0x81 -> after a claim and rescan, `irq_id`=3.
- Threshold:
  - ctl=0x40, nlbits=5 (level 0x47), threshold=0x47 -> never presented.
  - threshold=0x46 -> presented.
  - cur_level=0x47 -> not presented.
- Claim: present id 9, pulse `irq_ready` -> next cycle `claim_pulse`=1 and `claim_id`=9, `irq_valid`=0. With `int_ip[9]` cleared, no re-presentation of id 9.
- Withdraw and reset:
  - Clear `int_ie` of the presented id -> `irq_valid`=0 the next cycle, and no `claim_pulse` even if `irq_ready` is high in that cycle.
  - Assert `rst` mid-sweep -> reset values the next cycle.
